// File: rtl/vproc_result_wb_serializer.sv
// vproc_result_wb_serializer
// Takes one multi-result beat from the unit result mux and replays it onto a
// single vector register write port, one result per write in ascending order.
// Each beat produces exactly one completion cycle (pending-clear and
// instruction-done pulses), emitted in accept order.

module vproc_result_wb_serializer #(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned RES_CNT        = 2,
    parameter int unsigned MAX_RES_W      = 32,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           sync_rst_i,

    input  logic                           pipe_in_valid_i,
    output logic                           pipe_in_ready_o,
    input  logic [XIF_ID_W-1:0]            pipe_in_instr_id_i,
    input  logic [4:0]                     pipe_in_vaddr_i,
    input  logic [RES_CNT-1:0]             pipe_in_res_store_i,
    input  logic [RES_CNT-1:0]             pipe_in_res_valid_i,
    input  logic [RES_CNT*MAX_RES_W-1:0]   pipe_in_res_data_i,
    input  logic [RES_CNT*MAX_RES_W-1:0]   pipe_in_res_mask_i,
    input  logic                           pipe_in_pend_clear_i,
    input  logic [1:0]                     pipe_in_pend_clear_cnt_i,
    input  logic                           pipe_in_instr_done_i,

    output logic                           vreg_wr_valid_o,
    input  logic                           vreg_wr_ready_i,
    output logic [4:0]                     vreg_wr_addr_o,
    output logic [MAX_RES_W-1:0]           vreg_wr_data_o,
    output logic [MAX_RES_W-1:0]           vreg_wr_mask_o,

    output logic                           pend_clear_o,
    output logic [1:0]                     pend_clear_cnt_o,
    output logic [4:0]                     pend_clear_addr_o,
    output logic                           instr_done_valid_o,
    output logic [XIF_ID_W-1:0]            instr_done_id_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Everything needed to emit one completion cycle for a beat.
    typedef struct packed {
        logic                pc;
        logic [1:0]          cnt;
        logic [4:0]          addr;
        logic                done;
        logic [XIF_ID_W-1:0] id;
    } cmpl_t;

    state_t                       r_state;
    logic [RES_CNT-1:0]           r_pend;

    // Captured beat payload
    logic [4:0]                   r_vaddr;
    logic [RES_CNT*MAX_RES_W-1:0] r_data;
    logic [RES_CNT*MAX_RES_W-1:0] r_mask;
    logic                         r_pc;
    logic [1:0]                   r_pc_cnt;
    logic                         r_done;
    logic [XIF_ID_W-1:0]          r_id;

    // Completion output register plus a one-entry skid slot. The skid is
    // needed when a beat with nothing to write is accepted in the same cycle
    // as the previous beat's final write: both want the next cycle, so the
    // later one is held for one cycle to keep one completion per cycle.
    cmpl_t                        r_out;
    cmpl_t                        r_skid;
    logic                         r_skid_vld;

    logic [RES_CNT-1:0]           w_wr_set;
    logic [1:0]                   w_k;
    logic [RES_CNT-1:0]           w_k_onehot;
    logic [MAX_RES_W-1:0]         w_data;
    logic [MAX_RES_W-1:0]         w_mask;
    logic                         w_wr_valid;
    logic                         w_wr_hs;
    logic                         w_last;
    logic                         w_final_hs;
    logic                         w_ready;
    logic                         w_accept;
    logic                         w_ev_a;
    logic                         w_ev_b;
    cmpl_t                        w_cmpl_a;
    cmpl_t                        w_cmpl_b;

    assign w_wr_set   = pipe_in_res_store_i & pipe_in_res_valid_i;
    assign w_wr_valid = (r_state == ST_WRITE);
    assign w_wr_hs    = w_wr_valid & vreg_wr_ready_i;
    assign w_last     = ((r_pend & ~w_k_onehot) == '0);
    assign w_final_hs = w_wr_hs & w_last;
    assign w_ready    = (r_state == ST_IDLE) | w_final_hs;
    assign w_accept   = pipe_in_valid_i & w_ready;

    // Completion events: A = final write of the captured beat retires,
    // B = a beat with an empty write set is accepted.
    assign w_ev_a   = w_final_hs;
    assign w_ev_b   = w_accept & (w_wr_set == '0);
    assign w_cmpl_a = '{pc: r_pc, cnt: r_pc_cnt, addr: r_vaddr, done: r_done, id: r_id};
    assign w_cmpl_b = '{pc: pipe_in_pend_clear_i, cnt: pipe_in_pend_clear_cnt_i,
                        addr: pipe_in_vaddr_i, done: pipe_in_instr_done_i,
                        id: pipe_in_instr_id_i};

    // Select the lowest pending result and its data/mask words.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_k        = '0;
        w_k_onehot = '0;
        w_data     = '0;
        w_mask     = '0;
        for (int i = int'(RES_CNT) - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_k           = 2'(i);
                w_k_onehot    = '0;
                w_k_onehot[i] = 1'b1;
                w_data        = r_data[i*MAX_RES_W +: MAX_RES_W];
                w_mask        = r_mask[i*MAX_RES_W +: MAX_RES_W];
            end
        end
    end

    // Beat FSM: accept in IDLE (or on the final write), then drain pending results.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (sync_rst_i) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
        end else if (w_accept) begin
            r_pend  <= w_wr_set;
            r_state <= (w_wr_set != '0) ? ST_WRITE : ST_IDLE;
        end else if (w_wr_hs) begin
            r_pend  <= r_pend & ~w_k_onehot;
            if (w_last) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Beat payload capture on accept.
    always_ff @(posedge clk_i) begin
        // NOTE: payload registers carry no reset; they are only observed while r_state/r_out qualify them.
        if (w_accept) begin
            r_vaddr  <= pipe_in_vaddr_i;
            r_data   <= pipe_in_res_data_i;
            r_mask   <= pipe_in_res_mask_i;
            r_pc     <= pipe_in_pend_clear_i;
            r_pc_cnt <= pipe_in_pend_clear_cnt_i;
            r_done   <= pipe_in_instr_done_i;
            r_id     <= pipe_in_instr_id_i;
        end
    end

    // Completion sequencing: skid entry first, then retiring beat, then empty beat.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            r_out      <= r_skid;
            r_skid     <= w_cmpl_b;
            r_skid_vld <= w_ev_b;
        end else if (w_ev_a) begin
            r_out      <= w_cmpl_a;
            r_skid     <= w_cmpl_b;
            r_skid_vld <= w_ev_b;
        end else if (w_ev_b) begin
            r_out      <= w_cmpl_b;
        end else begin
            r_out      <= '0;
        end
    end

    assign pipe_in_ready_o    = w_ready;

    assign vreg_wr_valid_o    = w_wr_valid;
    assign vreg_wr_addr_o     = w_wr_valid ? (r_vaddr + {3'b000, w_k}) : (DONT_CARE_ZERO ? '0 : 'x);
    assign vreg_wr_data_o     = w_wr_valid ? w_data : (DONT_CARE_ZERO ? '0 : 'x);
    assign vreg_wr_mask_o     = w_wr_valid ? w_mask : (DONT_CARE_ZERO ? '0 : 'x);

    assign pend_clear_o       = r_out.pc;
    assign pend_clear_cnt_o   = r_out.pc ? r_out.cnt : (DONT_CARE_ZERO ? '0 : 'x);
    assign pend_clear_addr_o  = r_out.pc ? r_out.addr : (DONT_CARE_ZERO ? '0 : 'x);
    assign instr_done_valid_o = r_out.done;
    assign instr_done_id_o    = r_out.done ? r_out.id : (DONT_CARE_ZERO ? '0 : 'x);

endmodule
